// File: rtl/kbd_display_ctrl_if.sv
// Keyboard-to-display bundle: letter strobes in, anode/code/status out.
interface kbd_display_ctrl_if;
  logic [4:0] letter;
  logic       letter_valid;
  logic       clear;
  logic [3:0] an;
  logic [4:0] digit_code;
  logic       digit_blank;
  logic [2:0] count;
  logic       full;

  modport master (
    output letter, letter_valid, clear,
    input  an, digit_code, digit_blank, count, full
  );

  modport slave (
    input  letter, letter_valid, clear,
    output an, digit_code, digit_blank, count, full
  );
endinterface

// File: rtl/kbd_display_ctrl.sv
// Four-digit scan controller with a 4-deep letter shift buffer.
// d0 is the newest letter and is shown on the rightmost digit (an[0]).
// Each slot starts with BLANK_CYCLES of all-anodes-off to suppress ghosting.
module kbd_display_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic              clk,
  input logic              rst,
  kbd_display_ctrl_if.slave bus
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYCLES);
  localparam logic [4:0]    CODE_NONE = 5'd31;
  localparam logic [4:0]    CODE_BS   = 5'd30;
  localparam logic [4:0]    CODE_MAXL = 5'd25;

  logic [DW-1:0] div;
  logic [1:0]    slot;
  logic [4:0]    d [4];
  logic [2:0]    cnt;

  // Slot timer: div runs 0..REFRESH_DIV-1, then advances to the next digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      slot <= 2'd0;
    end else if (div == DIV_LAST) begin
      div  <= '0;
      slot <= slot + 2'd1;
    end else begin
      div  <= div + DW'(1);
    end
  end

  // Letter buffer: clear wins over a same-cycle letter; full buffer drops d3.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      for (int i = 0; i < 4; i++) d[i] <= CODE_NONE;
      cnt <= 3'd0;
    end else if (bus.letter_valid && (bus.letter <= CODE_MAXL)) begin
      d[3] <= d[2];
      d[2] <= d[1];
      d[1] <= d[0];
      d[0] <= bus.letter;
      if (cnt != 3'd4) cnt <= cnt + 3'd1;
    end else if (bus.letter_valid && (bus.letter == CODE_BS) && (cnt != 3'd0)) begin
      d[0] <= d[1];
      d[1] <= d[2];
      d[2] <= d[3];
      d[3] <= CODE_NONE;
      cnt  <= cnt - 3'd1;
    end
  end

  // Registered display outputs; blank window keeps every anode off.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.an          <= 4'b1111;
      bus.digit_code  <= CODE_NONE;
      bus.digit_blank <= 1'b1;
    end else if (div < BLANK_END) begin
      bus.an          <= 4'b1111;
      bus.digit_code  <= CODE_NONE;
      bus.digit_blank <= 1'b1;
    end else begin
      bus.an          <= ~(4'b0001 << slot);
      bus.digit_code  <= d[slot];
      bus.digit_blank <= (d[slot] == CODE_NONE);
    end
  end

  assign bus.count = cnt;
  assign bus.full  = (cnt == 3'd4);

endmodule

// File: tb/tb_kbd_display_ctrl.sv
// Directed bench for kbd_display_ctrl with an 8-cycle slot and 2-cycle blank.
module tb_kbd_display_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] exp_an;
  logic [1:0] s;
  logic       found;

  kbd_display_ctrl_if bus();

  kbd_display_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic strobe(input logic [4:0] code);
    bus.letter       = code;
    bus.letter_valid = 1'b1;
    step();
    bus.letter_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  // Land on the first displayed cycle of slot sl (after a blank gap).
  task automatic wait_slot(input logic [1:0] sl);
    logic got_blank;
    logic got;
    got_blank = 1'b0;
    got       = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (bus.an == 4'b1111) got_blank = 1'b1;
      else if (got_blank && bus.an == ~(4'b0001 << sl)) got = 1'b1;
    end
    chk("slot_reached", {31'd0, got}, 32'd1);
  endtask

  task automatic show(input string tag, input logic [1:0] sl, input logic [4:0] code);
    wait_slot(sl);
    chk(tag, {27'd0, bus.digit_code}, {27'd0, code});
    chk({tag, "_blank"}, {31'd0, bus.digit_blank}, {31'd0, (code == 5'd31)});
  endtask

  initial begin
    rst              = 1'b1;
    bus.letter       = 5'd0;
    bus.letter_valid = 1'b0;
    bus.clear        = 1'b0;
    step(); step(); step();

    chk("rst_an",    {28'd0, bus.an}, 32'hF);
    chk("rst_code",  {27'd0, bus.digit_code}, 32'd31);
    chk("rst_blank", {31'd0, bus.digit_blank}, 32'd1);
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    chk("rst_full",  {31'd0, bus.full}, 32'd0);

    // Scan pattern: per 8-cycle slot, 2 blank cycles then the slot anode.
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      s = 2'((k - 1) / 8);
      if (((k - 1) % 8) < 2) exp_an = 4'b1111;
      else                   exp_an = ~(4'b0001 << s);
      chk($sformatf("scan_an_c%0d", k), {28'd0, bus.an}, {28'd0, exp_an});
      chk($sformatf("scan_blank_c%0d", k), {31'd0, bus.digit_blank}, 32'd1);
    end

    // A, B, C
    strobe(5'd0); strobe(5'd1); strobe(5'd2);
    chk("abc_count", {29'd0, bus.count}, 32'd3);
    chk("abc_full",  {31'd0, bus.full}, 32'd0);
    show("abc_s0", 2'd0, 5'd2);
    show("abc_s1", 2'd1, 5'd1);
    show("abc_s2", 2'd2, 5'd0);
    show("abc_s3", 2'd3, 5'd31);

    // Five letters into the buffer; the first is pushed out.
    do_clear();
    chk("clr_count", {29'd0, bus.count}, 32'd0);
    for (int i = 0; i < 5; i++) strobe(5'(i));
    chk("five_count", {29'd0, bus.count}, 32'd4);
    chk("five_full",  {31'd0, bus.full}, 32'd1);
    show("five_s0", 2'd0, 5'd4);
    show("five_s1", 2'd1, 5'd3);
    show("five_s2", 2'd2, 5'd2);
    show("five_s3", 2'd3, 5'd1);

    // Backspace from d1=5, d0=6.
    do_clear();
    strobe(5'd5); strobe(5'd6);
    chk("bs_pre_count", {29'd0, bus.count}, 32'd2);
    strobe(5'd30);
    chk("bs1_count", {29'd0, bus.count}, 32'd1);
    chk("bs1_full",  {31'd0, bus.full}, 32'd0);
    show("bs1_s0", 2'd0, 5'd5);
    show("bs1_s1", 2'd1, 5'd31);
    strobe(5'd30);
    chk("bs2_count", {29'd0, bus.count}, 32'd0);
    strobe(5'd30);
    chk("bs3_count", {29'd0, bus.count}, 32'd0);
    show("bs3_s0", 2'd0, 5'd31);

    // clear beats a same-cycle letter.
    strobe(5'd9);
    chk("pre_clr_count", {29'd0, bus.count}, 32'd1);
    bus.clear = 1'b1;
    strobe(5'd7);
    bus.clear = 1'b0;
    chk("clr_valid_count", {29'd0, bus.count}, 32'd0);
    show("clr_valid_s0", 2'd0, 5'd31);

    // Ignored codes.
    strobe(5'd27);
    chk("ign_empty_count", {29'd0, bus.count}, 32'd0);
    strobe(5'd3);
    strobe(5'd27);
    strobe(5'd31);
    chk("ign_count", {29'd0, bus.count}, 32'd1);
    show("ign_s0", 2'd0, 5'd3);

    // A write while slot 0 is lit shows up on the following cycle.
    wait_slot(2'd0);
    strobe(5'd12);
    chk("live_old", {27'd0, bus.digit_code}, 32'd3);
    step();
    chk("live_new", {27'd0, bus.digit_code}, 32'd12);
    chk("live_an",  {28'd0, bus.an}, 32'hE);

    // Reset in the middle of slot 2.
    wait_slot(2'd2);
    step();
    rst = 1'b1;
    step();
    chk("mrst_an",    {28'd0, bus.an}, 32'hF);
    chk("mrst_count", {29'd0, bus.count}, 32'd0);
    rst = 1'b0;
    step();
    chk("mrst_c1", {28'd0, bus.an}, 32'hF);
    step();
    chk("mrst_c2", {28'd0, bus.an}, 32'hF);
    step();
    chk("mrst_c3", {28'd0, bus.an}, 32'hE);
    chk("mrst_code", {27'd0, bus.digit_code}, 32'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
